// File: rtl/fixed_to_float_norm.sv
// rtl/fixed_to_float_norm.sv - unsigned fixed-point to float normaliser; FIXED_TO_FLOAT_ROUND_EN enables round-to-nearest-even
module fixed_to_float_norm #(
    parameter int FIXEDSIZE      = 32,
    parameter int RADIXPOINTSIZE = 6,
    parameter int EXPONENTBITS   = 8,
    parameter int MANTISSABITS   = 23,
    parameter int BIAS           = 2**(EXPONENTBITS-1)-1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      InStart,
    input  logic [FIXEDSIZE-1:0]      InFixed,
    input  logic [RADIXPOINTSIZE-1:0] InRadixPoint,
    output logic [EXPONENTBITS-1:0]   OutExponent,
    output logic [MANTISSABITS-1:0]   OutMantissa,
    output logic                      OutZero,
    output logic                      OutOverflow,
    output logic                      OutUnderflow,
    output logic                      OutBusy,
    output logic                      OutDone
);

    // Exponent is evaluated two bits wider than the field so that both
    // overflow and negative (underflow) results are representable.
    localparam int EW = EXPONENTBITS + 2;
    localparam int LW = $clog2(FIXEDSIZE) + 1;
    // Bits below the mantissa that are discarded after normalisation.
    localparam int DW = FIXEDSIZE - 1 - MANTISSABITS;
    localparam logic signed [EW-1:0] EXPMAX = EW'((2**EXPONENTBITS) - 1);
    localparam logic signed [EW-1:0] EXPONE = EW'(1);

    typedef enum logic [1:0] {IDLE, NORM, DONE} stateT;

    stateT                     state;
    stateT                     stateNext;
    logic [FIXEDSIZE-1:0]      shiftReg;
    logic [RADIXPOINTSIZE-1:0] radixReg;
    logic [LW-1:0]             lzCount;

    logic signed [EW-1:0]      expCalc;
    logic [MANTISSABITS-1:0]   mantCalc;
    logic [EXPONENTBITS-1:0]   resExp;
    logic [MANTISSABITS-1:0]   resMant;
    logic                      resZero;
    logic                      resOverflow;
    logic                      resUnderflow;

`ifdef FIXED_TO_FLOAT_ROUND_EN
    logic                      guardBit;
    logic                      stickyBit;
    logic                      roundUp;
    logic [MANTISSABITS:0]     mantSum;

    if (DW >= 2) begin : gGuardSticky
        assign guardBit  = shiftReg[DW-1];
        assign stickyBit = |shiftReg[DW-2:0];
    end else if (DW == 1) begin : gGuardOnly
        assign guardBit  = shiftReg[0];
        assign stickyBit = 1'b0;
    end else begin : gNoDiscard
        assign guardBit  = 1'b0;
        assign stickyBit = 1'b0;
    end
`else
    if (DW >= 1) begin : gTruncated
        logic unusedLowBits;
        assign unusedLowBits = ^shiftReg[DW-1:0];
    end
`endif

    assign OutBusy = (state == NORM);
    assign OutDone = (state == DONE);

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: zero input skips normalisation; DONE always returns to IDLE
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (InStart) begin
                    stateNext = (InFixed == '0) ? DONE : NORM;
                end
            end
            NORM: begin
                if (shiftReg[FIXEDSIZE-1]) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Result from the normalised shift register, with saturation and flush-to-zero
    always_comb begin
        expCalc  = EW'(BIAS + FIXEDSIZE - 1) - EW'(lzCount) - EW'(radixReg);
        mantCalc = shiftReg[FIXEDSIZE-2 -: MANTISSABITS];
`ifdef FIXED_TO_FLOAT_ROUND_EN
        roundUp = guardBit & (stickyBit | mantCalc[0]);
        mantSum = {1'b0, mantCalc} + {{MANTISSABITS{1'b0}}, roundUp};
        if (mantSum[MANTISSABITS]) begin
            mantCalc = '0;
            expCalc  = expCalc + EW'(1);
        end else begin
            mantCalc = mantSum[MANTISSABITS-1:0];
        end
`endif
        resExp       = '0;
        resMant      = '0;
        resZero      = 1'b0;
        resOverflow  = 1'b0;
        resUnderflow = 1'b0;
        if (expCalc >= EXPMAX) begin
            resExp      = '1;
            resOverflow = 1'b1;
        end else if (expCalc < EXPONE) begin
            resZero      = 1'b1;
            resUnderflow = 1'b1;
        end else begin
            resExp  = expCalc[EXPONENTBITS-1:0];
            resMant = mantCalc;
        end
    end

    // Datapath: load on accepted start, shift until MSB set, register results at DONE entry
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            shiftReg     <= '0;
            radixReg     <= '0;
            lzCount      <= '0;
            OutExponent  <= '0;
            OutMantissa  <= '0;
            OutZero      <= 1'b0;
            OutOverflow  <= 1'b0;
            OutUnderflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InStart) begin
                        if (InFixed != '0) begin
                            shiftReg <= InFixed;
                            radixReg <= InRadixPoint;
                            lzCount  <= '0;
                        end else begin
                            OutExponent  <= '0;
                            OutMantissa  <= '0;
                            OutZero      <= 1'b1;
                            OutOverflow  <= 1'b0;
                            OutUnderflow <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    if (shiftReg[FIXEDSIZE-1]) begin
                        OutExponent  <= resExp;
                        OutMantissa  <= resMant;
                        OutZero      <= resZero;
                        OutOverflow  <= resOverflow;
                        OutUnderflow <= resUnderflow;
                    end else begin
                        shiftReg <= {shiftReg[FIXEDSIZE-2:0], 1'b0};
                        lzCount  <= lzCount + LW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
